// File: rtl/seq_data_checker.sv
// Sequence data checker: locks onto an incrementing data stream and counts matches/mismatches.
// Optional idle timeout enabled by defining SEQ_CHK_TIMEOUT_EN.
module seq_data_checker #(
    parameter int unsigned C_DATA_WIDTH  = 32,
    parameter int unsigned C_LOCK_NUM    = 4,
    parameter int unsigned C_LOSE_NUM    = 3,
    parameter int unsigned C_TIMEOUT_NUM = 1024
) (
    input  logic                    I_clk,
    input  logic                    I_rstn,
    input  logic                    I_enable,
    input  logic                    I_clrCnt,
    output logic                    O_rReady,
    input  logic                    I_dataEn,
    input  logic [C_DATA_WIDTH-1:0] I_data,
    output logic                    O_locked,
    output logic                    O_errFlg,
    output logic [15:0]             O_errCnt,
    output logic [31:0]             O_okCnt,
    output logic                    O_timeout
);

    typedef enum logic [1:0] {StIdle, StAcquire, StLocked} stateT;

    localparam logic [7:0] LockNum = 8'(C_LOCK_NUM);
    localparam logic [7:0] LoseNum = 8'(C_LOSE_NUM);

    stateT                   stateQ, stateD;
    logic                    rReadyQ;
    logic [C_DATA_WIDTH-1:0] expQ, expD;
    logic [7:0]              goodRunQ, goodRunD;
    logic [7:0]              badRunQ, badRunD;
    logic                    errFlgQ, errFlgD;
    logic [15:0]             errCntQ, errCntD;
    logic [31:0]             okCntQ, okCntD;

    logic                    accept;
    logic                    match;
    logic [C_DATA_WIDTH-1:0] dataNext;

`ifdef SEQ_CHK_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(C_TIMEOUT_NUM + 1);
    logic [IdleW-1:0] idleCntQ, idleCntD;
    logic             timeoutQ, timeoutD;
`else
    logic unusedCfg;
    assign unusedCfg = (C_TIMEOUT_NUM == 0);
`endif

    assign accept   = I_dataEn & rReadyQ;
    assign match    = (I_data == expQ);
    // Natural wrap gives modulo-2^W expectation, so all-ones -> 0 is a match.
    assign dataNext = I_data + C_DATA_WIDTH'(1);

    always_comb begin
        stateD   = stateQ;
        expD     = expQ;
        goodRunD = goodRunQ;
        badRunD  = badRunQ;
        errFlgD  = 1'b0;
        errCntD  = errCntQ;
        okCntD   = okCntQ;

        if (accept) begin
            expD = dataNext;
            unique case (stateQ)
                StIdle: begin
                    goodRunD = 8'd1;
                    stateD   = StAcquire;
                end
                StAcquire: begin
                    if (match) begin
                        goodRunD = goodRunQ + 8'd1;
                        if (goodRunQ + 8'd1 == LockNum) begin
                            stateD  = StLocked;
                            badRunD = 8'd0;
                        end
                    end else begin
                        goodRunD = 8'd1;
                    end
                end
                StLocked: begin
                    if (match) begin
                        okCntD  = okCntQ + 32'd1;
                        badRunD = 8'd0;
                    end else begin
                        errFlgD = 1'b1;
                        if (errCntQ != 16'hFFFF) begin
                            errCntD = errCntQ + 16'd1;
                        end
                        badRunD = badRunQ + 8'd1;
                        if (badRunQ + 8'd1 == LoseNum) begin
                            stateD   = StAcquire;
                            goodRunD = 8'd1;
                        end
                    end
                end
                default: stateD = StIdle;
            endcase
        end

        if (I_clrCnt) begin
            errCntD = 16'd0;
            okCntD  = 32'd0;
        end

`ifdef SEQ_CHK_TIMEOUT_EN
        idleCntD = '0;
        timeoutD = 1'b0;
        if (stateQ != StIdle && !accept) begin
            if (idleCntQ == IdleW'(C_TIMEOUT_NUM - 1)) begin
                timeoutD = 1'b1;
                stateD   = StIdle;
            end else begin
                idleCntD = idleCntQ + IdleW'(1);
            end
        end
`endif
    end

    always_ff @(posedge I_clk) begin
        if (!I_rstn) begin
            stateQ   <= StIdle;
            rReadyQ  <= 1'b0;
            expQ     <= '0;
            goodRunQ <= 8'd0;
            badRunQ  <= 8'd0;
            errFlgQ  <= 1'b0;
            errCntQ  <= 16'd0;
            okCntQ   <= 32'd0;
`ifdef SEQ_CHK_TIMEOUT_EN
            idleCntQ <= '0;
            timeoutQ <= 1'b0;
`endif
        end else begin
            stateQ   <= stateD;
            rReadyQ  <= I_enable;
            expQ     <= expD;
            goodRunQ <= goodRunD;
            badRunQ  <= badRunD;
            errFlgQ  <= errFlgD;
            errCntQ  <= errCntD;
            okCntQ   <= okCntD;
`ifdef SEQ_CHK_TIMEOUT_EN
            idleCntQ <= idleCntD;
            timeoutQ <= timeoutD;
`endif
        end
    end

    assign O_rReady = rReadyQ;
    assign O_locked = (stateQ == StLocked);
    assign O_errFlg = errFlgQ;
    assign O_errCnt = errCntQ;
    assign O_okCnt  = okCntQ;
`ifdef SEQ_CHK_TIMEOUT_EN
    assign O_timeout = timeoutQ;
`else
    assign O_timeout = 1'b0;
`endif

endmodule
